// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial multi-word adder with valid/ready handshakes
//
// Adds two 4*NIBBLES-bit operands one 4-bit slice per clock, LSB nibble first.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b/cin valid          in_ready  block can accept operands (IDLE)
//   a, b       operands (W bits)                cin       carry into nibble 0
//   out_valid  sum/cout/ovf valid (DONE)        out_ready consumer accepts result
//   sum        a+b+cin mod 2^W                  cout      carry out of bit W-1
//   ovf        two's-complement overflow        busy      high while in RUN
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [IDXW+1:0]   w_base;
    logic [W-1:0]      w_a_sh;
    logic [W-1:0]      w_b_sh;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_slice;
    logic              w_c3;
    logic              w_last;

    // Shifting the operand down by the slice offset selects the active nibble
    // without a variable part-select that could run past the top of the word.
    assign w_base  = {r_idx, 2'b00};
    assign w_a_sh  = r_a >> w_base;
    assign w_b_sh  = r_b >> w_base;
    assign w_a_nib = w_a_sh[3:0];
    assign w_b_nib = w_b_sh[3:0];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    // Carry into bit 3 of the slice, recovered from the sum bit and its inputs.
    assign w_c3    = w_a_nib[3] ^ w_b_nib[3] ^ w_slice[3];
    assign w_last  = (r_idx == IDXW'(NIBBLES - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_sum[4*i +: 4] <= w_slice[3:0];
                        end
                    end
                    r_carry <= w_slice[4];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice[4];
                        r_ovf  <= w_c3 ^ w_slice[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1)
module tb_nibble_serial_adder;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NIBBLES=4 instance
    logic        in_valid4 = 1'b0, out_ready4 = 1'b1, cin4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, ovf4, busy4;
    logic [15:0] sum4;

    // NIBBLES=1 instance
    logic        in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [3:0]  sum1;

    nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    exp_t q4[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a result is consumed when out_valid && out_ready at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out4: got sum 0x%0h expected no result", sum4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("sb4_sum", 32'(sum4), 32'(e.s));
                check("sb4_cout", 32'(cout4), 32'(e.c));
                check("sb4_ovf", 32'(ovf4), 32'(e.o));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out1: got sum 0x%0h expected no result", sum1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sb1_sum", 32'(sum1), 32'(e.s));
                check("sb1_cout", 32'(cout1), 32'(e.c));
                check("sb1_ovf", 32'(ovf1), 32'(e.o));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One add on the 4-nibble instance; bp = backpressure cycles, junk = in_valid held high with garbage.
    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input int bp, input bit junk);
        exp_t e;
        check("in_ready4_pre", 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
        e.s = es; e.c = ec; e.o = eo;
        q4.push_back(e);
        tick();
        if (junk) begin
            a4 = 16'hAAAA; b4 = 16'hAAAA; cin4 = 1'b1;
        end else begin
            in_valid4 = 1'b0;
        end
        out_ready4 = (bp == 0);
        for (int i = 0; i < 4; i++) begin
            check("busy4_run", 32'(busy4), 32'd1);
            check("out_valid4_run", 32'(out_valid4), 32'd0);
            check("in_ready4_run", 32'(in_ready4), 32'd0);
            tick();
        end
        check("out_valid4_lat", 32'(out_valid4), 32'd1);
        check("busy4_done", 32'(busy4), 32'd0);
        for (int i = 0; i < bp; i++) begin
            check("bp_in_ready4", 32'(in_ready4), 32'd0);
            check("bp_out_valid4", 32'(out_valid4), 32'd1);
            check("bp_sum4", 32'(sum4), 32'(es));
            check("bp_cout4", 32'(cout4), 32'(ec));
            check("bp_ovf4", 32'(ovf4), 32'(eo));
            tick();
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        tick();
        check("in_ready4_post", 32'(in_ready4), 32'd1);
        check("out_valid4_post", 32'(out_valid4), 32'd0);
        check("sum4_hold", 32'(sum4), 32'(es));
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [3:0] es, input logic ec, input logic eo);
        exp_t e;
        check("in_ready1_pre", 32'(in_ready1), 32'd1);
        a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
        e.s = 16'(es); e.c = ec; e.o = eo;
        q1.push_back(e);
        tick();
        in_valid1 = 1'b0;
        check("busy1_run", 32'(busy1), 32'd1);
        check("out_valid1_run", 32'(out_valid1), 32'd0);
        tick();
        check("out_valid1_lat", 32'(out_valid1), 32'd1);
        tick();
        check("in_ready1_post", 32'(in_ready1), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        check("rst_out_valid4", 32'(out_valid4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sum4", 32'(sum4), 32'h0);
        check("rst_cout4", 32'(cout4), 32'd0);
        check("rst_ovf4", 32'(ovf4), 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        check("rst_sum1", 32'(sum1), 32'h0);
        rst = 1'b0;
        tick();

        run4(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 1'b0);
        run4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        run4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 5, 1'b1);
        run4(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b1);

        // Reset during the second RUN cycle of 0xFFFF+0xFFFF: no result may appear.
        a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready4", 32'(in_ready4), 32'd1);
        check("midrst_busy4", 32'(busy4), 32'd0);
        check("midrst_sum4", 32'(sum4), 32'h0);
        check("midrst_cout4", 32'(cout4), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_out", 32'(out_valid4), 32'd0);
            tick();
        end
        run4(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

        run1(4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        run1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        run1(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);

        tick();
        tick();
        check("sb4_drained", 32'(q4.size()), 32'd0);
        check("sb1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-word adder that adds two NIBBLES*4-bit operands one 4-bit slice per clock, LSB nibble first, holding the inter-nibble carry in a register. Its single 4-bit add-with-carry slice is combinational. The block wraps that slice with operand/result registers, a sequencer and valid/ready handshakes on both sides. It sits between an operand producer (upstream valid/ready) and a result consumer (downstream valid/ready) wherever wide adds are needed at low area.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock, only clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a/b/cin valid.
in_ready  output  1  block can accept operands.
a  input  W  operand A.
b  input  W  operand B.
cin  input  1  carry into nibble 0.
out_valid  output  1  sum/cout/ovf valid.
out_ready  input  1  consumer accepts result.
sum  output  W  registered result a+b+cin mod 2^W.
cout  output  1  carry out of bit W-1.
ovf  output  1  two's-complement overflow: carry into bit W-1 XOR cout.
busy  output  1  high in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE. Registers: a_q, b_q (W), carry_q, idx (nibble index, ceil(log2(NIBBLES+1)) bits), sum_q, cout_q, ovf_q.
- Reset (rst high at a clk edge): state=IDLE, idx=0, carry_q=0, sum_q=0, cout_q=0, ovf_q=0. After the edge: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Reset overrides every other input in every state, including mid-RUN and mid-DONE. A partial result is discarded and never presented.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN). All three are decoded from registered state only, with no combinational path from in_valid or out_ready.
- IDLE: on in_valid && in_ready at an edge, capture a_q=a, b_q=b, carry_q=cin, sum_q=0, cout_q=0, ovf_q=0, idx=0, and go to RUN. a/b/cin are sampled only at this edge.
- RUN: each cycle computes {c, s} = a_q[4*idx+3:4*idx] + b_q[4*idx+3:4*idx] + carry_q. At the edge, sum_q nibble idx = s, carry_q = c, and idx increments.
  - When idx == NIBBLES-1 at the edge: cout_q = c, ovf_q = (carry into bit 3 of that slice) XOR c, and go to DONE.
  - in_valid is ignored in RUN and DONE; no operands are captured or queued.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 for the default). Throughput is one add per NIBBLES+2 cycles when out_ready is held high.
- DONE: sum/cout/ovf are held stable while out_valid=1 and out_ready=0, for any number of cycles. On out_ready at an edge, go to IDLE; sum_q/cout_q/ovf_q keep their values until the next accept.
- NIBBLES=1: RUN lasts one cycle; cout/ovf are taken from the only slice.
- Wrap-around: sum is mod 2^W. The carry out of the top nibble goes only to cout and is never fed back.

Test Plan:
- Reset then idle (NIBBLES=4): rst high for 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0x0000, cout=0, ovf=0.
- a=0x1234, b=0x4321, cin=1, accepted at edge E0 -> busy=1 for 4 cycles; out_valid=1 after E4; sum=0x5556, cout=0, ovf=0.
- Full ripple through every nibble: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf unchanged and in_ready=0 throughout. in_valid=1 with a=0xAAAA during RUN/DONE is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: rst asserted on the 2nd RUN cycle of 0xFFFF+0xFFFF -> after the edge, state=IDLE, sum=0, cout=0, and out_valid never asserts for that add. The next add 0x0003+0x0004 gives 0x0007.
- NIBBLES=1 build: a=0xF, b=0x1, cin=1 -> out_valid 1 cycle after accept; sum=0x1, cout=1, ovf=0. Also a=0x7, b=0x1, cin=0 -> sum=0x8, ovf=1.
